// File: rtl/mod_n_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mod_n_down_timer
//  Description : Loadable modulo-N down-counter/timer. A start loads the
//                reload value, enabled cycles decrement the count, and a
//                registered one-cycle terminal-count pulse marks expiry.
//                One-shot mode stops at expiry; periodic mode reloads.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_n_down_timer #(
   parameter int N = 100,
   localparam int W = $clog2(N)
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         start_i,
   input  logic         stop_i,
   input  logic         en_i,
   input  logic         auto_reload_i,
   output logic [W-1:0] count_o,
   output logic         busy_o,
   output logic         tc_o
);

   localparam logic [W-1:0] C_MAX = W'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t         state_q;
   logic [W-1:0]   count_q;
   logic [W-1:0]   rl_q;
   logic [W-1:0]   rl_d;
   logic           tc_q;
   logic [W-1:0]   w_load_clamped;

   // Out-of-range load values saturate at the modulus ceiling.
   assign w_load_clamped = (load_val_i > C_MAX) ? C_MAX : load_val_i;

   // Effective reload value: a same-cycle load takes precedence over the
   // stored value, so start/expiry in the load cycle see the new value.
   assign rl_d = load_i ? w_load_clamped : rl_q;

   // Timer state machine: reload register, count, state and tc pulse.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         count_q <= '0;
         rl_q    <= C_MAX;
         tc_q    <= 1'b0;
      end else begin
         rl_q <= rl_d;
         tc_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i && !stop_i) begin
                  count_q <= rl_d;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (stop_i) begin
                  state_q <= IDLE;
               end else if (start_i) begin
                  count_q <= rl_d;
               end else if (en_i) begin
                  if (count_q != '0) begin
                     count_q <= count_q - 1'b1;
                  end else begin
                     // Expiry: zero is never decremented, so no wrap.
                     tc_q <= 1'b1;
                     if (auto_reload_i) begin
                        count_q <= rl_d;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign count_o = count_q;
   assign busy_o  = (state_q == RUN);
   assign tc_o    = tc_q;

endmodule
`default_nettype wire
